// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - two-bit-per-cycle serial adder with registered carry
//
// Purpose:
//   Adds two WIDTH-bit unsigned operands plus a carry-in over N = WIDTH/2
//   cycles. Each cycle one 2-bit digit pair is added with the carry held in
//   a flip-flop, LSB digit first, and sum digits are shifted into an
//   accumulator. The complete result is loaded into sum/c_out at the end.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset, priority over everything
//   start  in   begin an add; accepted only when not busy (IDLE or DONE)
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   busy   out  high throughout the N RUN cycles
//   done   out  one-cycle pulse when sum/c_out have just been updated
//   sum    out  WIDTH-bit result of the last completed add
//   c_out  out  carry-out of the last completed add

// 2-bit add slice: {c_out, sum1, sum0} = {a1,a0} + {b1,b0} + cin
module digit_slice (
    input  logic a0,
    input  logic b0,
    input  logic a1,
    input  logic b1,
    input  logic cin,
    output logic sum0,
    output logic sum1,
    output logic c_out
);
    logic c_mid;

    always_comb begin
        sum0  = a0 ^ b0 ^ cin;
        c_mid = (a0 & b0) | (cin & (a0 ^ b0));
        sum1  = a1 ^ b1 ^ c_mid;
        c_out = (a1 & b1) | (c_mid & (a1 ^ b1));
    end
endmodule

module digit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int N  = WIDTH / 2;
    // Counter never narrower than one bit so WIDTH=2 still has a real register.
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [1:0]       digit;
    logic             digit_carry;
    logic [WIDTH-1:0] acc_next;

    digit_slice u_slice (
        .a0    (a_sh[0]),
        .b0    (b_sh[0]),
        .a1    (a_sh[1]),
        .b1    (b_sh[1]),
        .cin   (carry),
        .sum0  (digit[0]),
        .sum1  (digit[1]),
        .c_out (digit_carry)
    );

    // New digit enters at the top so that after N shifts the LSB digit has
    // reached bit 0; the completing edge loads this value straight into sum.
    generate
        if (WIDTH == 2) begin : g_acc_single
            assign acc_next = digit;
        end else begin : g_acc_shift
            assign acc_next = {digit, acc[WIDTH-1:2]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    a_sh  <= a_sh >> 2;
                    b_sh  <= b_sh >> 2;
                    acc   <= acc_next;
                    carry <= digit_carry;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= acc_next;
                        c_out <= digit_carry;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    done <= 1'b0;
                    // Back-to-back accept: same capture as from IDLE.
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - directed self-checking bench for digit_serial_adder
module tb_digit_serial_adder;
    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    int tests_run;
    int tests_failed;
    int done_count;

    digit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Accept an add at the next edge, then check busy for N cycles, the done
    // pulse and the result. prev_sum/prev_cout are the values sum/c_out must
    // hold during RUN.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                          input logic op_cin, input logic [WIDTH-1:0] prev_sum, input logic prev_cout,
                          input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        start = 1'b1; a = op_a; b = op_b; cin = op_cin;
        step();
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        for (int i = 0; i < N; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            if (i == 0) begin
                check({tag, "_sum_hold"}, 32'(sum), 32'(prev_sum));
                check({tag, "_cout_hold"}, 32'(c_out), 32'(prev_cout));
            end
            step();
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(c_out), 32'(exp_cout));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b1;

        // Reset held two cycles with start asserted.
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_sum", 32'(sum), 32'd0);
            check("rst_cout", 32'(c_out), 32'd0);
        end
        rst = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_idle_busy", 32'(busy), 32'd0);
            check("post_rst_idle_done", 32'(done), 32'd0);
        end

        // Basic add and hold afterwards.
        run_op("basic", 8'h5A, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h96, 1'b0);
        step();
        check("basic_done_pulse", 32'(done), 32'd0);
        check("basic_sum_after", 32'(sum), 32'h96);
        step();

        // Carry chain.
        run_op("carry1", 8'hFF, 8'h01, 1'b0, 8'h96, 1'b0, 8'h00, 1'b1);
        step();
        run_op("carry2", 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b1);
        step();

        // Start pulse during RUN must be ignored.
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        step();
        start = 1'b0; a = '0; b = '0;
        step();
        start = 1'b1; a = 8'hAA; b = 8'h55;
        step();
        start = 1'b0; a = '0; b = '0;
        done_count = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                done_count++;
                check("ign_sum", 32'(sum), 32'h30);
                check("ign_cout", 32'(c_out), 32'd0);
            end
            step();
        end
        check("ign_done_count", 32'(done_count), 32'd1);
        check("ign_idle", 32'(busy), 32'd0);

        // Back-to-back: start held in the DONE cycle.
        run_op("b2b_first", 8'h01, 8'h02, 1'b0, 8'h30, 1'b0, 8'h03, 1'b0);
        start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
        step();
        start = 1'b0; a = '0; b = '0;
        check("b2b_rebusy", 32'(busy), 32'd1);
        check("b2b_hold_sum", 32'(sum), 32'h03);
        for (int i = 1; i < N; i++) begin
            step();
            check("b2b_busy", 32'(busy), 32'd1);
            check("b2b_nodone", 32'(done), 32'd0);
        end
        step();
        check("b2b_second_done", 32'(done), 32'd1);
        check("b2b_second_sum", 32'(sum), 32'h00);
        check("b2b_second_cout", 32'(c_out), 32'd1);
        step();

        // Reset during the 2nd RUN cycle.
        start = 1'b1; a = 8'h7F; b = 8'h01; cin = 1'b0;
        step();
        start = 1'b0; a = '0; b = '0;
        step();
        check("midrst_running", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum", 32'(sum), 32'h00);
        check("midrst_cout", 32'(c_out), 32'd0);
        done_count = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) done_count++;
        end
        check("midrst_no_done", 32'(done_count), 32'd0);
        run_op("after_rst", 8'h7F, 8'h01, 1'b0, 8'h00, 1'b0, 8'h80, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
